// File: rtl/mux16_scan_sequencer.sv
// rtl/mux16_scan_sequencer.sv - drives a 16:1 mux through a select scan and streams back the checked results
module mux16_scan_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_first,
  input  logic [4:0]  in_count,
  output logic [15:0] mux_data,
  output logic [3:0]  mux_sel,
  input  logic        mux_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_bit,
  output logic [3:0]  out_sel,
  output logic        out_last,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  // Settle counter reload value; SETTLE is limited to 1..7 so three bits suffice.
  localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE - 1);

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_mux_data;
  logic [3:0]  r_mux_sel;
  logic [4:0]  r_remaining;
  logic [2:0]  r_settle_cnt;
  logic        r_out_valid;
  logic        r_out_bit;
  logic [3:0]  r_out_sel;
  logic        r_out_last;
  logic        r_done;
  logic        r_err;

  logic        w_cmd_accept;
  logic        w_capture;
  logic        w_out_accept;
  logic [4:0]  w_eff_count;
  logic        w_expected_bit;

  assign in_ready       = (r_state == S_IDLE);
  assign w_cmd_accept   = in_valid && (r_state == S_IDLE);
  assign w_capture      = (r_state == S_SETTLE) && (r_settle_cnt == 3'd0);
  assign w_out_accept   = (r_state == S_OUTPUT) && r_out_valid && out_ready;
  // A count of 0 or anything above 16 means a full 16-bit scan.
  assign w_eff_count    = ((in_count == 5'd0) || (in_count > 5'd16)) ? 5'd16 : in_count;
  // Reference bit comes from the registered word/select the mux is actually seeing.
  assign w_expected_bit = r_mux_data[r_mux_sel];

  assign mux_data  = r_mux_data;
  assign mux_sel   = r_mux_sel;
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_sel   = r_out_sel;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign err       = r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: accept a command, wait out the settle time, then hold the bit until taken.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_accept) begin
          w_next_state = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_capture) begin
          w_next_state = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (w_out_accept) begin
          w_next_state = r_out_last ? S_IDLE : S_SETTLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: mux drive registers, settle/remaining counters, output beat and check flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mux_data   <= 16'd0;
      r_mux_sel    <= 4'd0;
      r_remaining  <= 5'd0;
      r_settle_cnt <= 3'd0;
      r_out_valid  <= 1'b0;
      r_out_bit    <= 1'b0;
      r_out_sel    <= 4'd0;
      r_out_last   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_cmd_accept) begin
        r_mux_data   <= in_data;
        r_mux_sel    <= in_first;
        r_remaining  <= w_eff_count;
        r_settle_cnt <= SETTLE_LOAD;
        r_err        <= 1'b0;
      end

      if (r_state == S_SETTLE) begin
        if (w_capture) begin
          r_out_bit   <= mux_result;
          r_out_sel   <= r_mux_sel;
          r_out_last  <= (r_remaining == 5'd1);
          r_out_valid <= 1'b1;
          if (mux_result != w_expected_bit) begin
            r_err <= 1'b1;
          end
        end else begin
          r_settle_cnt <= r_settle_cnt - 3'd1;
        end
      end

      if (w_out_accept) begin
        r_out_valid <= 1'b0;
        if (r_out_last) begin
          r_done <= 1'b1;
        end else begin
          r_mux_sel    <= r_mux_sel + 4'd1;
          r_remaining  <= r_remaining - 5'd1;
          r_settle_cnt <= SETTLE_LOAD;
        end
      end
    end
  end

endmodule
